// File: rtl/iomem_gpio_bank.sv
// iomem_gpio_bank: WIDTH-channel GPIO on the picosoc iomem bus, one 16 MB window.
// Map: OUT 0x00, IN 0x04, OE 0x08; with GPIO_IRQ_EN: MASK 0x0C, STATUS 0x10 (w1c), EDGE 0x14.
// Ports: clk, reset (async, active high); iomem_valid/ready/wstrb/addr/wdata/rdata
//   bus slave; gpio_in raw pads; gpio_out/gpio_oe pad drive; irq level interrupt.
module iomem_gpio_bank #(
  parameter int unsigned WIDTH           = 8,
  parameter logic [7:0]  BASE_ADDR       = 8'h03,
  parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic             hit, wr;
  logic [7:0]       off;
  logic [31:0]      bmask, rd;
  logic [WIDTH-1:0] wmask, wd;
  logic             unused_bits;
`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] prev_q, clr, ev;
  logic             irq_q, irq_d;
`endif

  assign unused_bits = ^{iomem_addr[23:8], iomem_wdata, bmask};

  always_comb begin
    off   = iomem_addr[7:0];
    // ready_q blocks a second hit, so a held request acks every other cycle
    hit   = iomem_valid && !ready_q &&
            (iomem_addr[31:24] == BASE_ADDR);
    wr    = hit && (iomem_wstrb != 4'b0000);
    bmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
             {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    wmask = bmask[WIDTH-1:0];
    wd    = iomem_wdata[WIDTH-1:0];
    rd    = '0;
    out_d = out_q;
    oe_d  = oe_q;
`ifdef GPIO_IRQ_EN
    mask_d = mask_q;
    edge_d = edge_q;
    clr    = '0;
`endif
    unique case (off)
      8'h00: begin
        rd[WIDTH-1:0] = out_q;
        if (wr) out_d = (out_q & ~wmask) | (wd & wmask);
      end
      8'h04: rd[WIDTH-1:0] = deb_q;
      8'h08: begin
        rd[WIDTH-1:0] = oe_q;
        if (wr) oe_d = (oe_q & ~wmask) | (wd & wmask);
      end
`ifdef GPIO_IRQ_EN
      8'h0C: begin
        rd[WIDTH-1:0] = mask_q;
        if (wr) mask_d = (mask_q & ~wmask) | (wd & wmask);
      end
      8'h10: begin
        rd[WIDTH-1:0] = stat_q;
        if (wr) clr = wd & wmask;
      end
      8'h14: begin
        rd[WIDTH-1:0] = edge_q;
        if (wr) edge_d = (edge_q & ~wmask) | (wd & wmask);
      end
`endif
      default: ;
    endcase
    ready_d = hit;
    rdata_d = hit ? rd : '0;
  end

`ifdef GPIO_IRQ_EN
  always_comb begin
    ev     = (edge_q & deb_q & ~prev_q) |
             (~edge_q & ~deb_q & prev_q);
    // a new edge outranks a same-cycle clear
    stat_d = (stat_q & ~clr) | ev;
    irq_d  = |(stat_q & mask_q);
  end
`endif

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb deb_d = sync2_q;
    end else begin : g_deb
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt_q [WIDTH];
      logic [CW-1:0] cnt_d [WIDTH];

      always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_d[i] = '0;
          if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == LAST) deb_d[i] = sync2_q[i];
            else cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
      oe_q    <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
`ifdef GPIO_IRQ_EN
      mask_q  <= '0;
      stat_q  <= '0;
      edge_q  <= '0;
      prev_q  <= '0;
      irq_q   <= 1'b0;
`endif
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
`ifdef GPIO_IRQ_EN
      mask_q  <= mask_d;
      stat_q  <= stat_d;
      edge_q  <= edge_d;
      prev_q  <= deb_q;
      irq_q   <= irq_d;
`endif
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = oe_q;
`ifdef GPIO_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// tb_iomem_gpio_bank: directed table, corner sequences and random traffic
// against a behavioural model of the GPIO bank (WIDTH=8, DEBOUNCE_CYCLES=4).
module tb_iomem_gpio_bank;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iomem_gpio_bank #(
    .WIDTH(8),
    .BASE_ADDR(8'h03),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe(gpio_oe),
    .irq(irq)
  );

  // ---------------- reference model ----------------
  logic [7:0]  m_out, m_oe, m_mask, m_stat, m_edge;
  logic [7:0]  m_deb, m_prev, m_p1, m_p2;
  logic [7:0]  hist [DEB];
  logic        m_ready, m_irq;
  logic [31:0] m_rdata;
  logic        m_hit, m_wr;
  logic [7:0]  m_lane, m_wv;

  assign m_hit  = iomem_valid && !m_ready &&
                  (iomem_addr[31:24] == 8'h03);
  assign m_wr   = m_hit && (iomem_wstrb != 4'b0000);
  // only byte lane 0 reaches an 8-channel bank
  assign m_lane = {8{iomem_wstrb[0]}};
  assign m_wv   = iomem_wdata[7:0] & m_lane;

  function automatic logic [7:0] merge(input logic [7:0] old);
    return (old & ~m_lane) | m_wv;
  endfunction

  function automatic logic [31:0] read_reg(input logic [7:0] o);
    logic [7:0] v;
    case (o)
      8'h00: v = m_out;
      8'h04: v = m_deb;
      8'h08: v = m_oe;
`ifdef GPIO_IRQ_EN
      8'h0C: v = m_mask;
      8'h10: v = m_stat;
      8'h14: v = m_edge;
`endif
      default: v = 8'h00;
    endcase
    return {24'h0, v};
  endfunction

  // a channel flips once the last DEB synchronised samples all disagree with it
  function automatic logic [7:0] deb_next();
    logic [7:0] r;
    r = m_deb;
    for (int c = 0; c < 8; c++) begin
      int n;
      n = (m_p2[c] != m_deb[c]) ? 1 : 0;
      for (int k = 0; k < DEB - 1; k++)
        if (hist[k][c] != m_deb[c]) n++;
      if (n == DEB) r[c] = ~m_deb[c];
    end
    return r;
  endfunction

`ifdef GPIO_IRQ_EN
  function automatic logic [7:0] events();
    logic [7:0] e;
    for (int c = 0; c < 8; c++)
      e[c] = (m_deb[c] != m_prev[c]) && (m_deb[c] == m_edge[c]);
    return e;
  endfunction
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out <= 0; m_oe <= 0; m_mask <= 0; m_stat <= 0;
      m_edge <= 0; m_deb <= 0; m_prev <= 0;
      m_p1 <= 0; m_p2 <= 0;
      m_ready <= 0; m_irq <= 0; m_rdata <= 0;
      for (int k = 0; k < DEB; k++) hist[k] <= 8'h00;
    end else begin
      m_ready <= m_hit;
      m_rdata <= m_hit ? read_reg(iomem_addr[7:0]) : 32'h0;
      if (m_wr) begin
        case (iomem_addr[7:0])
          8'h00: m_out <= merge(m_out);
          8'h08: m_oe <= merge(m_oe);
`ifdef GPIO_IRQ_EN
          8'h0C: m_mask <= merge(m_mask);
          8'h14: m_edge <= merge(m_edge);
`endif
          default: ;
        endcase
      end
`ifdef GPIO_IRQ_EN
      m_stat <= (m_stat & ~((m_wr && iomem_addr[7:0] == 8'h10)
                 ? m_wv : 8'h00)) | events();
      m_irq  <= |(m_stat & m_mask);
`endif
      m_deb  <= deb_next();
      m_prev <= m_deb;
      m_p2   <= m_p1;
      m_p1   <= gpio_in;
      hist[0] <= m_p2;
      for (int k = 1; k < DEB; k++) hist[k] <= hist[k-1];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("ready", {31'h0, iomem_ready}, {31'h0, m_ready});
    chk("rdata", iomem_rdata, m_rdata);
    chk("gpio_out", {24'h0, gpio_out}, {24'h0, m_out});
    chk("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_oe});
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic bus(input logic [7:0] o, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r);
    iomem_valid = 1'b1;
    iomem_addr  = {8'h03, 16'h0, o};
    iomem_wstrb = s;
    iomem_wdata = d;
    tick();
    r = iomem_rdata;
    chk("ack", {31'h0, iomem_ready}, 32'h1);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    tick();
  endtask

  typedef struct {
    logic [7:0]  off;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] exp;
  } tvec_t;

  tvec_t tbl [16];

`ifdef GPIO_IRQ_EN
  localparam logic [31:0] MASK_RB = 32'hFF;
  localparam logic [31:0] STAT_EX = 32'h01;
`else
  localparam logic [31:0] MASK_RB = 32'h00;
  localparam logic [31:0] STAT_EX = 32'h00;
`endif

  logic [7:0] offs [8];

  initial begin
    logic [31:0] r;
    tbl[0]  = '{8'h08, 4'h1, 32'h000000A5, 32'h0};
    tbl[1]  = '{8'h00, 4'h1, 32'h0000005A, 32'h0};
    tbl[2]  = '{8'h00, 4'h0, 32'h0, 32'h5A};
    tbl[3]  = '{8'h08, 4'h0, 32'h0, 32'hA5};
    tbl[4]  = '{8'h00, 4'h2, 32'hFFFFFFFF, 32'h5A};
    tbl[5]  = '{8'h00, 4'h0, 32'h0, 32'h5A};
    tbl[6]  = '{8'h00, 4'hF, 32'h12345633, 32'h5A};
    tbl[7]  = '{8'h00, 4'h0, 32'h0, 32'h33};
    tbl[8]  = '{8'h20, 4'hF, 32'hFFFFFFFF, 32'h0};
    tbl[9]  = '{8'h20, 4'h0, 32'h0, 32'h0};
    tbl[10] = '{8'h04, 4'h0, 32'h0, 32'h0};
    tbl[11] = '{8'h0C, 4'hF, 32'h000000FF, 32'h0};
    tbl[12] = '{8'h0C, 4'h0, 32'h0, MASK_RB};
    tbl[13] = '{8'h0C, 4'hF, 32'h0, MASK_RB};
    tbl[14] = '{8'h08, 4'h1, 32'h000000A5, 32'hA5};
    tbl[15] = '{8'h00, 4'h1, 32'h0000005A, 32'h33};
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20};

    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    gpio_in     = 8'h00;
    repeat (2) tick();
    chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
    chk("rst_out", {24'h0, gpio_out}, 32'h0);
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].off, tbl[i].strb, tbl[i].wd, r);
      chk($sformatf("tbl%0d", i), r, tbl[i].exp);
    end
    chk("oe_final", {24'h0, gpio_oe}, 32'hA5);
    chk("out_final", {24'h0, gpio_out}, 32'h5A);

    // foreign window: never acknowledged
    iomem_valid = 1'b1;
    iomem_addr  = 32'h04000000;
    repeat (6) begin
      tick();
      chk("no_ack", {31'h0, iomem_ready}, 32'h0);
    end
    iomem_valid = 1'b0;
    tick();

    // 3-cycle glitch is rejected
    gpio_in[3] = 1'b1;
    repeat (3) tick();
    gpio_in[3] = 1'b0;
    repeat (10) tick();
    bus(8'h04, 4'h0, 32'h0, r);
    chk("glitch", r, 32'h0);

    // IN still 0 on the 6th edge after the pin change
    gpio_in[3] = 1'b1;
    repeat (5) tick();
    bus(8'h04, 4'h0, 32'h0, r);
    chk("in_edge6", r, 32'h0);
    bus(8'h04, 4'h0, 32'h0, r);
    chk("in_settled", r, 32'h08);
    gpio_in[3] = 1'b0;
    repeat (12) tick();

    // and 1 when sampled on the 7th edge
    gpio_in[3] = 1'b1;
    repeat (6) tick();
    bus(8'h04, 4'h0, 32'h0, r);
    chk("in_edge7", r, 32'h08);
    gpio_in[3] = 1'b0;
    repeat (12) tick();

    // edge interrupt, w1c, and set-beats-clear
    bus(8'h10, 4'hF, 32'hFF, r);
    bus(8'h0C, 4'h1, 32'h01, r);
    bus(8'h14, 4'h1, 32'h01, r);
    gpio_in[0] = 1'b1;
    repeat (10) tick();
    chk("irq_set", {31'h0, irq}, STAT_EX);
    bus(8'h10, 4'h0, 32'h0, r);
    chk("stat_set", r, STAT_EX);
    bus(8'h10, 4'h1, 32'h01, r);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    gpio_in[0] = 1'b0;
    repeat (10) tick();
    bus(8'h10, 4'h0, 32'h0, r);
    chk("stat_fall", r, 32'h0);
    gpio_in[0] = 1'b1;
    repeat (6) tick();
    bus(8'h10, 4'h1, 32'h01, r);
    bus(8'h10, 4'h0, 32'h0, r);
    chk("set_wins", r, STAT_EX);
    chk("irq_again", {31'h0, irq}, STAT_EX);

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        int b;
        b = $urandom_range(0, 7);
        gpio_in[b] = ~gpio_in[b];
      end
      iomem_valid = ($urandom_range(0, 2) == 0);
      iomem_addr  = {($urandom_range(0, 5) == 0) ? 8'h04 : 8'h03,
                     16'h0, offs[$urandom_range(0, 7)]};
      iomem_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      iomem_wdata = $urandom;
      tick();
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    repeat (2) tick();

    // reset in the middle of an acknowledged write
    iomem_valid = 1'b1;
    iomem_addr  = 32'h03000000;
    iomem_wstrb = 4'h1;
    iomem_wdata = 32'hFF;
    @(posedge clk);
    #1;
    chk("pre_rst_ack", {31'h0, iomem_ready}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", {31'h0, iomem_ready}, 32'h0);
    chk("mid_rst_rdata", iomem_rdata, 32'h0);
    chk("mid_rst_out", {24'h0, gpio_out}, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    repeat (3) tick();
    chk("post_rst_out", {24'h0, gpio_out}, 32'h0);
    bus(8'h00, 4'h0, 32'h0, r);
    chk("post_rst_rd", r, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
